// File: rtl/stack_sequencer.sv
// stack_sequencer
//
// Multi-cycle controller that walks the STACK_* push/pop register-list masks
// one slot per stack transfer. Pops run first (highest slot first), then
// pushes (lowest slot first). Push data comes from the register file, pop
// data goes back to it, and a private SP copy is written back once in FIN.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     begin a sequence (ignored while busy)
//   push_mask, pop_mask       16-bit slot sets, sampled at start
//   sp_in                     current SP, sampled at start
//   busy, done                sequence in progress / one-cycle completion pulse
//   mem_req, mem_wr           stack transfer request (held until mem_ack), 1 = push
//   mem_addr, mem_wdata       SS offset and push data of the current transfer
//   mem_ack, mem_rdata        transfer complete, pop data
//   reg_rd_sel, reg_rd_data   register-file read port for push data
//   reg_wr_en/sel/data        register-file write port for popped data
//   sp_wr_en, sp_wr_data      final SP write-back, coincident with done

module stack_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] push_mask,
    input  logic [15:0] pop_mask,
    input  logic [15:0] sp_in,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  reg_rd_sel,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_sel,
    output logic [15:0] reg_wr_data,
    output logic        sp_wr_en,
    output logic [15:0] sp_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Slot 4 is SP itself: it is never written back on pop, and on push it
    // stores the SP value as it was before the sequence began.
    localparam logic [3:0] SP_SLOT = 4'd4;

    state_t      state;
    state_t      state_next;

    logic [15:0] push_bits;
    logic [15:0] pop_bits;
    logic [15:0] sp;
    logic [15:0] orig_sp;

    logic [3:0]  push_slot;
    logic [3:0]  pop_slot;
    logic [15:0] push_remaining;
    logic [15:0] pop_remaining;

    // Lowest set bit of the push set (scan from the top so the last hit wins).
    always_comb begin
        push_slot = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (push_bits[i]) begin
                push_slot = 4'(i);
            end
        end
        push_remaining = push_bits & ~(16'h0001 << push_slot);
    end

    // Highest set bit of the pop set (scan from the bottom so the last hit wins).
    always_comb begin
        pop_slot = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pop_bits[i]) begin
                pop_slot = 4'(i);
            end
        end
        pop_remaining = pop_bits & ~(16'h0001 << pop_slot);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working masks and SP copy. A reset discards the partially updated SP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            push_bits <= 16'h0000;
            pop_bits  <= 16'h0000;
            sp        <= 16'h0000;
            orig_sp   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        push_bits <= push_mask;
                        pop_bits  <= pop_mask;
                        sp        <= sp_in;
                        orig_sp   <= sp_in;
                    end
                end
                POP: begin
                    if (mem_ack) begin
                        pop_bits <= pop_remaining;
                        sp       <= sp + 16'd2;
                    end
                end
                PUSH: begin
                    if (mem_ack) begin
                        push_bits <= push_remaining;
                        sp        <= sp - 16'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and all outputs. The bus fields depend only on registered
    // state (and the register-file read), so they hold steady across waits.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        reg_rd_sel  = 4'd0;
        reg_wr_en   = 1'b0;
        reg_wr_sel  = 4'd0;
        reg_wr_data = 16'h0000;
        sp_wr_en    = 1'b0;
        sp_wr_data  = 16'h0000;

        case (state)
            IDLE: begin
                if (start) begin
                    if (pop_mask != 16'h0000) begin
                        state_next = POP;
                    end else if (push_mask != 16'h0000) begin
                        state_next = PUSH;
                    end else begin
                        state_next = FIN;
                    end
                end
            end

            POP: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = sp;
                if (mem_ack) begin
                    if (pop_slot != SP_SLOT) begin
                        reg_wr_en   = 1'b1;
                        reg_wr_sel  = pop_slot;
                        reg_wr_data = mem_rdata;
                    end
                    if (pop_remaining == 16'h0000) begin
                        state_next = (push_bits != 16'h0000) ? PUSH : FIN;
                    end
                end
            end

            PUSH: begin
                busy       = 1'b1;
                reg_rd_sel = push_slot;
                mem_req    = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = sp - 16'd2;
                mem_wdata  = (push_slot == SP_SLOT) ? orig_sp : reg_rd_data;
                if (mem_ack && (push_remaining == 16'h0000)) begin
                    state_next = FIN;
                end
            end

            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                sp_wr_en   = 1'b1;
                sp_wr_data = sp;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
